fifo_rd_arbiter: RTL and testbench
==================================

# fifo_rd_arbiter

Read-side controller for the asynchronous FIFO. It shares the FIFO read port among NUM_REQ consumers using round-robin grants with bounded bursts, and sequences each pop against the registered empty flag. The popped data goes onto a single registered valid/ready output, steered by a one-hot grant. It sits entirely in the read clock domain, between the FIFO read port and the consumers.

## Interface
- DATA_WIDTH, 8, FIFO word width
- NUM_REQ, 4, number of consumers (≥2)
- MAX_BURST, 4, maximum beats per grant (≥1)

- rd_clk  input  1  read-domain clock; single clock for the block
- rst_n  input  1  reset, synchronous, active-low
- req  input  NUM_REQ  per-consumer read request, level
- fifo_rd_empty  input  1  registered empty flag from the FIFO
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en
- fifo_rd_en  output  1  FIFO pop strobe, one cycle per word
- out_gnt  output  NUM_REQ  one-hot owner of the current burst
- out_data  output  DATA_WIDTH  registered beat data
- out_valid  output  1  beat valid
- out_ready  input  1  beat accepted by the granted consumer
- out_last  output  1  final beat of the burst
- busy  output  1  state ≠ IDLE

## Operation
- FSM states: IDLE, GRANT, POP, LOAD, SEND. All outputs are registered or decoded from the state register only.
  - fifo_rd_en = (state==POP).
  - out_valid = (state==SEND).
  - busy = (state!=IDLE).
- IDLE:
  - If |req, select the winner by round-robin and go to GRANT.
  - Latch out_gnt to the winner and clear beat_cnt.
  - If req==0, stay in IDLE.
- Round-robin: search starts at index last_gnt+1 (mod NUM_REQ) and wraps. last_gnt is updated to the winner on burst release.
- GRANT, checked in this priority order:
  - If req[winner]==0, clear out_gnt, update last_gnt and go to IDLE.
  - Else if fifo_rd_empty==0, go to POP.
  - Else stay in GRANT; out_gnt is held.
- POP: assert fifo_rd_en for exactly one cycle, then go to LOAD.
- LOAD: capture out_data ← fifo_rd_data and out_last ← (beat_cnt==MAX_BURST-1), then go to SEND.
- SEND: hold out_data, out_valid and out_last until out_ready. On out_ready, increment beat_cnt, then:
  - If out_last, clear out_gnt, update last_gnt and go to IDLE.
  - Otherwise go to GRANT.
- Pops are at least 3 cycles apart (POP→LOAD→SEND→GRANT→POP). This covers the one-cycle lag of the registered empty flag after a pop, so the block never pops an empty FIFO.
- A req deassert is only honoured in GRANT. A beat already popped is always delivered through SEND.
- beat_cnt is $clog2(MAX_BURST+1) bits, so it never wraps within a burst. With MAX_BURST=1, every beat has out_last=1.
- Reset values (rst_n low at a rising edge): state=IDLE, out_gnt=0, out_data=0, out_valid=0, out_last=0, fifo_rd_en=0, busy=0, beat_cnt=0, last_gnt=NUM_REQ-1, so req[0] has highest priority after reset.
- Reset mid-operation: reset takes effect at the next edge. A word popped in POP/LOAD, or pending in SEND, is discarded. Losing that word is accepted behaviour.

## Timing
- Edge E0: req sampled in IDLE → GRANT; out_gnt is valid after E0.
- Edge E1: fifo_rd_empty==0 sampled → POP; fifo_rd_en is high for the cycle E1–E2.
- Edge E2: → LOAD; fifo_rd_data is valid during E2–E3.
- Edge E3: → SEND; out_valid, out_data and out_last are high from E3.
- First-beat latency from req to out_valid is 3 edges with a non-empty FIFO.
- Steady throughput is 1 beat per 4 cycles with out_ready held high.
- Between bursts, IDLE adds 1 cycle before the next grant.

## Structure
- Shared package fifo_ctrl_pkg: FSM state localparams (3-bit encoding) and the beat_cnt width function.
- One sub-module, rr_arbiter: combinational rotate-priority pick. Inputs are req and last_gnt; output is the one-hot winner. Instantiated once.

## Test plan
- Reset then req=4'b0001, FIFO holding 0xA1,0xA2: out_gnt=0001; fifo_rd_en pulses at E1; out_data=0xA1 with out_valid at E3; second beat out_data=0xA2.
- req=4'b1111 held, FIFO continuously non-empty, MAX_BURST=4: grants in order 0001, 0010, 0100, 1000, 0001. out_last is high on every 4th beat. No fifo_rd_en pulses occur less than 3 cycles apart.
- fifo_rd_empty=1 while req[2] is granted: stays in GRANT, fifo_rd_en=0, out_gnt=0100. Empty drops → POP on the next edge.
- out_ready low for 5 cycles in SEND: out_data, out_valid and out_last stay stable. No further pop occurs until the beat is accepted.
- req[1] drops after beat 2 of 4: the in-flight beat is delivered; at GRANT, out_gnt→0 and out_last is never asserted. The next grant goes to req[2] if it is pending.
- rst_n low during LOAD: after the edge, all outputs are 0 and state is IDLE. The popped word is never presented, and req[0] wins next.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_pkg
// Brief    : Shared state encoding and sizing helpers for the FIFO read side.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_grant = 3'd1;
    localparam logic [2:0] c_st_pop   = 3'd2;
    localparam logic [2:0] c_st_load  = 3'd3;
    localparam logic [2:0] c_st_send  = 3'd4;

    // One extra count of headroom so the beat counter never wraps mid-burst.
    function automatic int beat_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotate-priority pick starting after the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_gnt,
    output logic [NUM_REQ-1:0] o_winner
);

    always_comb begin
        int   v_idx;
        logic v_found;
        o_winner = '0;
        v_found  = 1'b0;
        v_idx    = 0;
        // Offsets 1..NUM_REQ visit every index once, the previous owner last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            v_idx = (int'(i_last_gnt) + i) % NUM_REQ;
            if (!v_found && i_req[v_idx[IDX_W-1:0]]) begin
                o_winner[v_idx[IDX_W-1:0]] = 1'b1;
                v_found                    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arbiter
// Brief    : Round-robin, burst-bounded read-port sharing for the async FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [NUM_REQ-1:0]    out_gnt,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int                 c_idx_w        = $clog2(NUM_REQ);
    localparam int                 c_cnt_w        = beat_cnt_width(MAX_BURST);
    localparam logic [c_cnt_w-1:0] c_last_beat    = c_cnt_w'(MAX_BURST - 1);
    localparam logic [c_idx_w-1:0] c_last_gnt_rst = c_idx_w'(NUM_REQ - 1);

    logic [2:0]            r_state,    w_state_nxt;
    logic [NUM_REQ-1:0]    r_gnt,      w_gnt_nxt;
    logic [DATA_WIDTH-1:0] r_data,     w_data_nxt;
    logic                  r_last,     w_last_nxt;
    logic [c_cnt_w-1:0]    r_beat_cnt, w_cnt_nxt;
    logic [c_idx_w-1:0]    r_last_gnt, w_last_gnt_nxt;
    logic [NUM_REQ-1:0]    w_winner;
    logic                  w_owner_req;
    logic [c_idx_w-1:0]    w_gnt_idx;

    function automatic logic [c_idx_w-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [c_idx_w-1:0] v_idx;
        v_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) v_idx = c_idx_w'(i);
        end
        return v_idx;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .i_req      (req),
        .i_last_gnt (r_last_gnt),
        .o_winner   (w_winner)
    );

    assign w_owner_req = |(req & r_gnt);
    assign w_gnt_idx   = onehot_to_idx(r_gnt);

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_gnt      <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_beat_cnt <= '0;
            r_last_gnt <= c_last_gnt_rst;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_data     <= w_data_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_data_nxt     = r_data;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_beat_cnt;
        w_last_gnt_nxt = r_last_gnt;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                if (|req) begin
                    w_gnt_nxt   = w_winner;
                    w_state_nxt = c_st_grant;
                end
            end
            c_st_grant: begin
                // Request withdrawal is only honoured here, never mid-beat.
                if (!w_owner_req) begin
                    w_gnt_nxt      = '0;
                    w_last_gnt_nxt = w_gnt_idx;
                    w_state_nxt    = c_st_idle;
                end else if (!fifo_rd_empty) begin
                    w_state_nxt = c_st_pop;
                end
            end
            c_st_pop: begin
                w_state_nxt = c_st_load;
            end
            c_st_load: begin
                w_data_nxt  = fifo_rd_data;
                w_last_nxt  = (r_beat_cnt == c_last_beat);
                w_state_nxt = c_st_send;
            end
            c_st_send: begin
                if (out_ready) begin
                    w_cnt_nxt = r_beat_cnt + c_cnt_w'(1);
                    if (r_last) begin
                        w_gnt_nxt      = '0;
                        w_last_gnt_nxt = w_gnt_idx;
                        w_state_nxt    = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_grant;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign fifo_rd_en = (r_state == c_st_pop);
    assign out_valid  = (r_state == c_st_send);
    assign busy       = (r_state != c_st_idle);
    assign out_gnt    = r_gnt;
    assign out_data   = r_data;
    assign out_last   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Brief    : Directed self-checking bench for fifo_rd_arbiter with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

    logic       rd_clk;
    logic       rst_n;
    logic [3:0] req;
    logic       fifo_rd_empty;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en;
    logic [3:0] out_gnt;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    logic [7:0] q[$];
    logic       model_empty = 1'b1;
    logic       force_empty;
    int         n_checks = 0;
    int         n_pass   = 0;

    fifo_rd_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .rd_clk        (rd_clk),
        .rst_n         (rst_n),
        .req           (req),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .out_gnt       (out_gnt),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Registered-empty FIFO read port: data one cycle after the pop strobe.
    always @(posedge rd_clk) begin
        if (fifo_rd_en && q.size() != 0) fifo_rd_data <= q.pop_front();
        model_empty <= (q.size() == 0);
    end
    assign fifo_rd_empty = model_empty | force_empty;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !out_valid; i++) tick();
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        int beats;
        int cyc;
        int last_pop;
        int viol;
        logic [3:0] e_gnt;

        force_empty = 1'b0;
        out_ready   = 1'b1;
        req         = 4'b0000;

        // ---- reset state, then single requester with two words ----
        q.delete();
        q.push_back(8'hA1);
        q.push_back(8'hA2);
        reset_dut();
        check("rst_gnt",   {28'd0, out_gnt}, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_data",  {24'd0, out_data}, 32'h0);
        check("rst_last",  {31'd0, out_last}, 32'd0);
        rst_n = 1'b1;
        req   = 4'b0001;
        tick();
        check("t1_e0_gnt",   {28'd0, out_gnt}, 32'h1);
        check("t1_e0_busy",  {31'd0, busy}, 32'd1);
        check("t1_e0_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        check("t1_e1_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        check("t1_e2_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("t1_e2_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_e3_valid", {31'd0, out_valid}, 32'd1);
        check("t1_e3_data",  {24'd0, out_data}, 32'hA1);
        check("t1_e3_last",  {31'd0, out_last}, 32'd0);
        tick();
        check("t1_e4_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_e5_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        tick();
        check("t1_e7_valid", {31'd0, out_valid}, 32'd1);
        check("t1_e7_data",  {24'd0, out_data}, 32'hA2);
        req = 4'b0000;
        tick();
        tick();
        check("t1_rel_gnt",  {28'd0, out_gnt}, 32'h0);
        check("t1_rel_busy", {31'd0, busy}, 32'd0);

        // ---- all requesting, continuous data: rotation and burst length ----
        q.delete();
        for (int i = 0; i < 24; i++) q.push_back(8'(8'h10 + i));
        reset_dut();
        rst_n    = 1'b1;
        req      = 4'b1111;
        beats    = 0;
        cyc      = 0;
        last_pop = -100;
        viol     = 0;
        while (beats < 20 && cyc < 300) begin
            tick();
            cyc++;
            if (fifo_rd_en) begin
                if (cyc - last_pop < 3) viol++;
                last_pop = cyc;
            end
            if (out_valid) begin
                e_gnt = 4'b0001 << ((beats / 4) % 4);
                check($sformatf("rr_gnt_b%0d", beats),  {28'd0, out_gnt}, {28'd0, e_gnt});
                check($sformatf("rr_last_b%0d", beats), {31'd0, out_last}, {31'd0, (beats % 4) == 3});
                check($sformatf("rr_data_b%0d", beats), {24'd0, out_data}, 32'h10 + 32'(beats));
                beats++;
            end
        end
        req = 4'b0000;
        check("rr_beat_count", 32'(beats), 32'd20);
        check("rr_pop_gap_violations", 32'(viol), 32'd0);
        tick();
        tick();

        // ---- empty FIFO while req[2] owns the grant, then out_ready stall ----
        q.delete();
        q.push_back(8'hC3);
        force_empty = 1'b1;
        reset_dut();
        rst_n = 1'b1;
        req   = 4'b0100;
        tick();
        check("t3_gnt", {28'd0, out_gnt}, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3_hold_rd_en%0d", i), {31'd0, fifo_rd_en}, 32'd0);
            check($sformatf("t3_hold_gnt%0d", i),   {28'd0, out_gnt}, 32'h4);
        end
        force_empty = 1'b0;
        out_ready   = 1'b0;
        tick();
        check("t3_pop_after_empty", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        tick();
        check("t4_send_valid", {31'd0, out_valid}, 32'd1);
        check("t4_send_data",  {24'd0, out_data}, 32'hC3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_stall_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("t4_stall_data%0d", i),  {24'd0, out_data}, 32'hC3);
            check($sformatf("t4_stall_last%0d", i),  {31'd0, out_last}, 32'd0);
            check($sformatf("t4_stall_rd_en%0d", i), {31'd0, fifo_rd_en}, 32'd0);
        end
        out_ready = 1'b1;
        req       = 4'b0000;
        tick();
        check("t4_accept_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t4_release_gnt", {28'd0, out_gnt}, 32'h0);

        // ---- owner drops request mid-burst; next grant rotates onward ----
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(8'(8'h50 + i));
        reset_dut();
        rst_n = 1'b1;
        req   = 4'b0110;
        wait_valid("t5_beat1_timeout", 20);
        check("t5_b1_gnt",  {28'd0, out_gnt}, 32'h2);
        check("t5_b1_data", {24'd0, out_data}, 32'h50);
        check("t5_b1_last", {31'd0, out_last}, 32'd0);
        tick();
        wait_valid("t5_beat2_timeout", 20);
        check("t5_b2_data", {24'd0, out_data}, 32'h51);
        check("t5_b2_last", {31'd0, out_last}, 32'd0);
        req = 4'b0100;
        tick();
        check("t5_delivered_valid", {31'd0, out_valid}, 32'd0);
        check("t5_grant_held",      {28'd0, out_gnt}, 32'h2);
        tick();
        check("t5_drop_gnt",  {28'd0, out_gnt}, 32'h0);
        check("t5_drop_busy", {31'd0, busy}, 32'd0);
        check("t5_drop_last", {31'd0, out_last}, 32'd0);
        tick();
        check("t5_next_gnt", {28'd0, out_gnt}, 32'h4);
        req = 4'b0000;
        tick();
        tick();

        // ---- reset while a popped word sits in LOAD ----
        q.delete();
        q.push_back(8'h60);
        q.push_back(8'h61);
        reset_dut();
        rst_n = 1'b1;
        req   = 4'b0001;
        tick();
        tick();
        check("t6_pop", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        check("t6_rst_gnt",   {28'd0, out_gnt}, 32'h0);
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_data",  {24'd0, out_data}, 32'h0);
        check("t6_rst_last",  {31'd0, out_last}, 32'd0);
        check("t6_rst_busy",  {31'd0, busy}, 32'd0);
        check("t6_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        check("t6_req0_wins", {28'd0, out_gnt}, 32'h1);
        wait_valid("t6_beat_timeout", 20);
        check("t6_next_word", {24'd0, out_data}, 32'h61);
        req = 4'b0000;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
